// File: rtl/valet_dispatch_scheduler.sv
// Central dispatch sequencer for the valet arena lanes: arbitrates arrivals and
// returns into a single outstanding lane command and enforces stall/drop timeouts.
module valet_dispatch_scheduler #(
    parameter int ID_W        = 8,
    parameter int STALL_LIMIT = 10,
    parameter int DROP_LIMIT  = 20,
    parameter int RET_BURST   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            arr_valid,
    input  logic [ID_W-1:0] arr_id,
    input  logic [1:0]      arr_pref,
    output logic            arr_ready,
    input  logic            ret_valid,
    input  logic [ID_W-1:0] ret_id,
    input  logic [1:0]      ret_lane,
    output logic            ret_ready,
    input  logic [2:0]      lane_full,
    output logic            cmd_valid,
    output logic            cmd_op,
    output logic [1:0]      cmd_lane,
    output logic [ID_W-1:0] cmd_id,
    input  logic            lane_ack,
    input  logic            lane_hit,
    output logic            done_valid,
    output logic            done_ok,
    output logic            stall_evt,
    output logic            drop_evt,
    output logic [ID_W-1:0] evt_id,
    output logic            busy
);

    localparam int SC_W = $clog2(STALL_LIMIT + 1);
    localparam int WC_W = $clog2(DROP_LIMIT + 1);
    localparam int RS_W = $clog2(RET_BURST + 1);
    localparam logic [SC_W-1:0] STALL_LAST = SC_W'(STALL_LIMIT - 1);
    localparam logic [WC_W-1:0] WAIT_LAST  = WC_W'(DROP_LIMIT - 1);
    localparam logic [RS_W-1:0] STREAK_MAX = RS_W'(RET_BURST);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK} state_t;

    state_t          state_q, state_d;
    logic            op_q, op_d;
    logic [1:0]      lane_q, lane_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [RS_W-1:0] streak_q, streak_d;
    logic [SC_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            done_d, ok_d, stall_evt_d, drop_d;
    logic [ID_W-1:0] evt_id_d;
    logic            arr_take, ret_take;
    logic            all_full, arr_elig, ret_win, arr_win;
    logic [1:0]      p0, p1, p2, arr_lane;

    assign all_full = &lane_full;
    assign arr_elig = arr_valid & ~all_full;
    assign ret_win  = ret_valid & ~((streak_q == STREAK_MAX) & arr_elig);
    assign arr_win  = arr_elig & ~ret_win;

    // Walk pref, pref+1, pref+2 (mod 3) and take the first lane with room.
    always_comb begin
        p0 = (arr_pref == 2'b11) ? 2'd0 : arr_pref;
        p1 = (p0 == 2'd2) ? 2'd0 : p0 + 2'd1;
        p2 = (p1 == 2'd2) ? 2'd0 : p1 + 2'd1;
        if (!lane_full[p0])
            arr_lane = p0;
        else if (!lane_full[p1])
            arr_lane = p1;
        else
            arr_lane = p2;
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        lane_d      = lane_q;
        id_d        = id_q;
        streak_d    = streak_q;
        stall_cnt_d = stall_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        done_d      = 1'b0;
        ok_d        = 1'b0;
        stall_evt_d = 1'b0;
        drop_d      = 1'b0;
        evt_id_d    = '0;
        arr_take    = 1'b0;
        ret_take    = 1'b0;
        if (!arr_valid)
            stall_cnt_d = '0;
        case (state_q)
            IDLE: begin
                if (ret_win) begin
                    ret_take = 1'b1;
                    if (streak_q != STREAK_MAX)
                        streak_d = streak_q + RS_W'(1);
                    // Unknown lane: nothing to dequeue, report it as lost right away.
                    if (ret_lane == 2'b11) begin
                        done_d   = 1'b1;
                        drop_d   = 1'b1;
                        evt_id_d = ret_id;
                    end else begin
                        op_d    = 1'b1;
                        lane_d  = ret_lane;
                        id_d    = ret_id;
                        state_d = ISSUE;
                    end
                end else if (arr_win) begin
                    arr_take    = 1'b1;
                    streak_d    = '0;
                    stall_cnt_d = '0;
                    op_d        = 1'b0;
                    lane_d      = arr_lane;
                    id_d        = arr_id;
                    state_d     = ISSUE;
                end else if (arr_valid && all_full) begin
                    if (stall_cnt_q == STALL_LAST) begin
                        arr_take    = 1'b1;
                        stall_cnt_d = '0;
                        stall_evt_d = 1'b1;
                        evt_id_d    = arr_id;
                    end else begin
                        stall_cnt_d = stall_cnt_q + SC_W'(1);
                    end
                end
            end
            ISSUE: begin
                state_d    = WAIT_ACK;
                wait_cnt_d = '0;
            end
            WAIT_ACK: begin
                if (lane_ack) begin
                    done_d      = 1'b1;
                    ok_d        = lane_hit;
                    drop_d      = op_q & ~lane_hit;
                    stall_evt_d = ~op_q & ~lane_hit;
                    evt_id_d    = id_q;
                    state_d     = IDLE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    done_d      = 1'b1;
                    drop_d      = op_q;
                    stall_evt_d = ~op_q;
                    evt_id_d    = id_q;
                    state_d     = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + WC_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= 1'b0;
            lane_q      <= '0;
            id_q        <= '0;
            streak_q    <= '0;
            stall_cnt_q <= '0;
            wait_cnt_q  <= '0;
            done_valid  <= 1'b0;
            done_ok     <= 1'b0;
            stall_evt   <= 1'b0;
            drop_evt    <= 1'b0;
            evt_id      <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            lane_q      <= lane_d;
            id_q        <= id_d;
            streak_q    <= streak_d;
            stall_cnt_q <= stall_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            done_valid  <= done_d;
            done_ok     <= ok_d;
            stall_evt   <= stall_evt_d;
            drop_evt    <= drop_d;
            evt_id      <= evt_id_d;
        end
    end

    // Ready is masked during reset so nothing is consumed while the block is held.
    assign arr_ready = arr_take & rst_n;
    assign ret_ready = ret_take & rst_n;
    assign cmd_valid = (state_q == ISSUE);
    assign cmd_op    = cmd_valid & op_q;
    assign cmd_lane  = cmd_valid ? lane_q : 2'b00;
    assign cmd_id    = cmd_valid ? id_q : '0;
    assign busy      = (state_q != IDLE);

endmodule

// File: doc/valet_dispatch_scheduler.md
# valet_dispatch_scheduler

Central sequencer for the valet arena datapath. It arbitrates car arrivals and return requests into a single command stream for the shared LIFO/FIFO/CAM lanes, keeping one lane command outstanding at a time. It selects a lane for each arrival with fallback when lanes are full, and enforces the stall and drop timeouts. Its done, stall and drop pulses feed the tip/penalty logic downstream.

## Interface
- ID_W, 8, car identifier width
- STALL_LIMIT, 10, cycles an arrival may wait with all lanes full before it is discarded
- DROP_LIMIT, 20, cycles WAIT_ACK may last without lane_ack before timeout
- RET_BURST, 2, consecutive return grants after which a pending eligible arrival wins

- clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- arr_valid  in  1  arrival request pending
- arr_id  in  ID_W  arriving car id
- arr_pref  in  2  preferred lane: 00 LIFO, 01 FIFO, 10 CAM, 11 treated as 00
- arr_ready  out  1  arrival consumed this cycle (combinational)
- ret_valid  in  1  return request pending
- ret_id  in  ID_W  car id to retrieve
- ret_lane  in  2  lane holding the car; 11 = unknown
- ret_ready  out  1  return consumed this cycle (combinational)
- lane_full  in  3  bit0 LIFO, bit1 FIFO, bit2 CAM full
- cmd_valid  out  1  one-cycle lane command strobe
- cmd_op  out  1  0 enqueue, 1 dequeue
- cmd_lane  out  2  target lane
- cmd_id  out  ID_W  car id of command
- lane_ack  in  1  lane completed the outstanding command
- lane_hit  in  1  qualifies lane_ack: 1 success, 0 miss/reject
- done_valid  out  1  command completion pulse
- done_ok  out  1  completion succeeded
- stall_evt  out  1  stall event pulse
- drop_evt  out  1  drop event pulse
- evt_id  out  ID_W  car id for done/stall/drop pulse
- busy  out  1  state != IDLE

## Operation
- States: IDLE, ISSUE, WAIT_ACK. Only IDLE accepts requests; ready signals are 0 in all other states.
- Arrival eligibility: arr_valid is high and at least one lane_full bit is 0.
- IDLE arbitration: a return wins if ret_valid is high, unless ret_streak==RET_BURST and an arrival is eligible.
- Streak: ret_streak increments on each return grant, saturating at RET_BURST. It clears on each arrival grant.
- Lane choice for an arrival: the first non-full lane in the order pref, pref+1, pref+2 (mod 3).
- On grant: latch op/lane/id and go to ISSUE. In ISSUE, drive cmd_valid=1 for exactly one cycle, then go to WAIT_ACK with wait_cnt=0.
- Return with ret_lane=11: consume it, issue no command, pulse drop_evt and done_valid with done_ok=0, and stay in IDLE.
- WAIT_ACK, on lane_ack:
  - Pulse done_valid with done_ok=lane_hit and go to IDLE.
  - A dequeue with hit=0 also pulses drop_evt.
  - An enqueue with hit=0 also pulses stall_evt.
- WAIT_ACK, no ack: wait_cnt increments each cycle. After DROP_LIMIT cycles without ack, time out:
  - A dequeue pulses drop_evt.
  - An enqueue pulses stall_evt.
  - Both pulse done_valid with done_ok=0, then go to IDLE.
- lane_ack is ignored outside WAIT_ACK. An ack on the same cycle as the timeout counts as an ack, not a timeout.
- Stall counter:
  - stall_cnt increments each IDLE cycle that arr_valid=1 and all lanes are full.
  - On reaching STALL_LIMIT, assert arr_ready to discard the arrival, pulse stall_evt with evt_id=arr_id, and clear the counter.
  - Clears when arr_valid=0 or the arrival is granted. It holds (does not clear) while a return is being serviced.
- Counters stop at their limits; no wrap.

## Timing
- Reset: state IDLE, all outputs 0, ret_streak, stall_cnt and wait_cnt all 0.
- Reset mid-command abandons the command with no pulses.
- Grant at cycle T: cmd_valid at T+1. Earliest lane_ack is at T+2.
- done_valid, stall_evt, drop_evt and evt_id are registered, one-cycle pulses, asserted the cycle after their cause. The state is IDLE in that same cycle, so the next grant can occur the cycle done_valid is high.
- Minimum throughput: one command per 3 cycles.
- Simultaneous arr_valid and ret_valid: resolved by the streak rule. The losing request holds, and its valid must stay high.

## Test plan
- Reset, then arrival id=0x11 with pref=01 and lanes free:
  - arr_ready at T.
  - cmd_valid/op=0/lane=01/id=0x11 at T+1.
  - ack with hit=1 at T+3, then done_valid with done_ok=1 and evt_id=0x11 at T+4.
- lane_full=011 and arrival pref=00 -> cmd_lane=10. With lane_full=111 held 10 cycles -> arr_ready on the 10th IDLE cycle, then stall_evt with evt_id=arr_id, and no cmd_valid.
- ret_valid and arr_valid held continuously, all acks immediate -> grant order return, return, arrival, return, return, arrival.
- Return id=0x22, lane=10, with no ack -> after 20 WAIT_ACK cycles, drop_evt=1, done_valid=1, done_ok=0 and busy=0 on the next cycle. An ack arriving later is ignored.
- Return with ret_lane=11 -> drop_evt with no cmd_valid. Return with hit=0 -> drop_evt and done_ok=0.
- rst_n low during WAIT_ACK -> all outputs 0 the next cycle and no pulses.
